multicycle_ctrl: RTL and testbench

Moore-style control FSM that sequences a multicycle MIPS datapath: one instruction takes 3–5 cycles, and the memory is shared between instruction and data access. It decodes op/funct from the instruction register and drives every datapath select and write-enable. It stalls on a memory-ready handshake. It sits beside the datapath in the CPU top level, replacing the single-cycle main decoder.

---
 rtl/multicycle_ctrl_pkg.sv | 85 ++++++++
 rtl/multicycle_ctrl_aludec.sv | 30 +++
 rtl/multicycle_ctrl.sv | 160 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding,
// opcode/funct constants, ALUop and alucontrol codes, decode helpers.
// The optional bne support is selected with MULTICYCLE_CTRL_BNE_EN.
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEX   = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] AC_AND = 3'b000;
   localparam logic [2:0] AC_OR  = 3'b001;
   localparam logic [2:0] AC_ADD = 3'b010;
   localparam logic [2:0] AC_SUB = 3'b110;
   localparam logic [2:0] AC_SLT = 3'b111;

   // Datapath controls produced by the state decoder (before reset gating)
   typedef struct packed {
      logic       mem_req;
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       pcwrite;
      logic       branch;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
   } ctrl_t;

   // State that follows DECODE for a given opcode; unknown opcodes restart fetch
   function automatic state_t f_decode_next(input logic [5:0] op, input bit bne_en);
      case (op)
         OP_LW, OP_SW: return S_MEMADR;
         OP_RTYPE:     return S_EXECUTE;
         OP_BEQ:       return S_BRANCH;
         OP_BNE:       return bne_en ? S_BRANCH : S_FETCH;
         OP_ADDI:      return S_ADDIEX;
         OP_J:         return S_JUMP;
         default:      return S_FETCH;
      endcase
   endfunction

   // True when the opcode is implemented by this controller build
   function automatic logic f_op_legal(input logic [5:0] op, input bit bne_en);
      case (op)
         OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
         OP_BNE:  return bne_en;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_ctrl_aludec.sv
// Combinational ALU decoder: ALUop plus funct field to alucontrol code.
module multicycle_aludec
   import multicycle_ctrl_pkg::*;
(
   input  aluop_t     i_aluop,
   input  logic [5:0] i_funct,
   output logic [2:0] o_alucontrol
);

   // Add/sub are forced by the FSM; R-type takes the funct field
   always_comb begin
      o_alucontrol = AC_ADD;
      case (i_aluop)
         ALUOP_ADD: o_alucontrol = AC_ADD;
         ALUOP_SUB: o_alucontrol = AC_SUB;
         ALUOP_FUNCT: begin
            case (i_funct)
               FN_ADD:  o_alucontrol = AC_ADD;
               FN_SUB:  o_alucontrol = AC_SUB;
               FN_AND:  o_alucontrol = AC_AND;
               FN_OR:   o_alucontrol = AC_OR;
               FN_SLT:  o_alucontrol = AC_SLT;
               default: o_alucontrol = AC_ADD;
            endcase
         end
         default: o_alucontrol = AC_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS datapath with a shared memory and a
// mem_ready stall handshake. Define MULTICYCLE_CTRL_BNE_EN to add bne.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       pcen,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic [2:0] alucontrol,
   output logic       illegal_op
);

   state_t r_state;
   ctrl_t  w_ctl;
   aluop_t w_aluop;
   logic   w_zero_eff;
   logic   w_op_legal;

`ifdef MULTICYCLE_CTRL_BNE_EN
   localparam bit BNE_EN = 1'b1;
   logic r_bne;

   // Remember whether the instruction in flight is bne; captured in DECODE
   always_ff @(posedge clk) begin
      if (reset)
         r_bne <= 1'b0;
      else if (r_state == S_DECODE)
         r_bne <= (op == OP_BNE);
   end

   assign w_zero_eff = r_bne ? ~zero : zero;
`else
   localparam bit BNE_EN = 1'b0;
   assign w_zero_eff = zero;
`endif

   assign w_op_legal = f_op_legal(op, BNE_EN);

   // State register and transitions; memory states hold until mem_ready
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         case (r_state)
            S_FETCH:    if (mem_ready) r_state <= S_DECODE;
            S_DECODE:   r_state <= f_decode_next(op, BNE_EN);
            S_MEMADR:   r_state <= (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
            S_MEMWB:    r_state <= S_FETCH;
            S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
            S_EXECUTE:  r_state <= S_ALUWB;
            S_ALUWB:    r_state <= S_FETCH;
            S_BRANCH:   r_state <= S_FETCH;
            S_ADDIEX:   r_state <= S_ADDIWB;
            S_ADDIWB:   r_state <= S_FETCH;
            S_JUMP:     r_state <= S_FETCH;
            default:    r_state <= S_FETCH;
         endcase
      end
   end

   // Per-state control decode; mem_ready only qualifies the fetch strobes
   always_comb begin
      w_ctl   = '0;
      w_aluop = ALUOP_ADD;
      case (r_state)
         S_FETCH: begin
            w_ctl.mem_req = 1'b1;
            w_ctl.alusrcb = 2'b01;
            w_ctl.irwrite = mem_ready;
            w_ctl.pcwrite = mem_ready;
         end
         S_DECODE: begin
            w_ctl.alusrcb = 2'b11;
         end
         S_MEMADR: begin
            w_ctl.alusrca = 1'b1;
            w_ctl.alusrcb = 2'b10;
         end
         S_MEMREAD: begin
            w_ctl.mem_req = 1'b1;
            w_ctl.iord    = 1'b1;
         end
         S_MEMWB: begin
            w_ctl.memtoreg = 1'b1;
            w_ctl.regwrite = 1'b1;
         end
         S_MEMWRITE: begin
            w_ctl.mem_req  = 1'b1;
            w_ctl.iord     = 1'b1;
            w_ctl.memwrite = 1'b1;
         end
         S_EXECUTE: begin
            w_ctl.alusrca = 1'b1;
            w_aluop       = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            w_ctl.regdst   = 1'b1;
            w_ctl.regwrite = 1'b1;
         end
         S_BRANCH: begin
            w_ctl.alusrca = 1'b1;
            w_ctl.pcsrc   = 2'b01;
            w_ctl.branch  = 1'b1;
            w_aluop       = ALUOP_SUB;
         end
         S_ADDIEX: begin
            w_ctl.alusrca = 1'b1;
            w_ctl.alusrcb = 2'b10;
         end
         S_ADDIWB: begin
            w_ctl.regwrite = 1'b1;
         end
         S_JUMP: begin
            w_ctl.pcsrc   = 2'b10;
            w_ctl.pcwrite = 1'b1;
         end
         default: begin
            w_ctl   = '0;
            w_aluop = ALUOP_ADD;
         end
      endcase
   end

   multicycle_aludec u_aludec (
      .i_aluop      (w_aluop),
      .i_funct      (funct),
      .o_alucontrol (alucontrol)
   );

   // Select lines pass straight through; strobes are killed during reset so
   // an abandoned instruction never writes on the reset cycle
   assign iord       = w_ctl.iord;
   assign alusrca    = w_ctl.alusrca;
   assign alusrcb    = w_ctl.alusrcb;
   assign pcsrc      = w_ctl.pcsrc;
   assign regdst     = w_ctl.regdst;
   assign memtoreg   = w_ctl.memtoreg;
   assign mem_req    = ~reset & w_ctl.mem_req;
   assign memwrite   = ~reset & w_ctl.memwrite;
   assign irwrite    = ~reset & w_ctl.irwrite;
   assign regwrite   = ~reset & w_ctl.regwrite;
   assign pcen       = ~reset & (w_ctl.pcwrite | (w_ctl.branch & w_zero_eff));
   assign illegal_op = ~reset & (r_state == S_DECODE) & ~w_op_legal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: an instruction-level model predicts
// every output each cycle under random ops, mem_ready and zero, plus directed
// sequences with literal expectations. Honours MULTICYCLE_CTRL_BNE_EN.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, iord, memwrite, irwrite, pcen, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic       regdst, memtoreg, regwrite, illegal_op;
   logic [2:0] alucontrol;

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .memwrite(memwrite),
      .irwrite(irwrite), .pcen(pcen), .alusrca(alusrca), .alusrcb(alusrcb),
      .pcsrc(pcsrc), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
      .alucontrol(alucontrol), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   typedef enum int {C_LW, C_SW, C_RT, C_BEQ, C_BNE, C_ADDI, C_J, C_ILL} cls_t;

   typedef struct packed {
      logic       mem_req, iord, memwrite, irwrite, pcen, alusrca;
      logic [1:0] alusrcb, pcsrc;
      logic       regdst, memtoreg, regwrite;
      logic       chk_alu;
      logic [2:0] alu;
      logic       illegal;
      logic       holds;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   cls_t m_cls = C_ILL;
   int   m_k = 0;
   bit   m_new = 1'b0;
   bit   rst_next = 1'b1;
   logic [5:0] op_q[$];
   logic [5:0] fn_q[$];
   bit   mr_q[$];
   bit   z_q[$];

   function automatic cls_t classify(input logic [5:0] o);
      case (o)
         6'b100011: return C_LW;
         6'b101011: return C_SW;
         6'b000000: return C_RT;
         6'b000100: return C_BEQ;
`ifdef MULTICYCLE_CTRL_BNE_EN
         6'b000101: return C_BNE;
`endif
         6'b001000: return C_ADDI;
         6'b000010: return C_J;
         default:   return C_ILL;
      endcase
   endfunction

   // Cycles per instruction with no stalls
   function automatic int ilen(input cls_t c);
      case (c)
         C_LW:               return 5;
         C_SW, C_RT, C_ADDI: return 4;
         C_BEQ, C_BNE, C_J:  return 3;
         default:            return 2;
      endcase
   endfunction

   function automatic logic [2:0] fdec(input logic [5:0] fn);
      case (fn)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Expected outputs for cycle k of an instruction of class c
   function automatic exp_t model(input cls_t c, input int k, input bit mr,
                                  input bit z, input logic [5:0] fn);
      exp_t e;
      e = '0;
      if (k == 0) begin
         e.mem_req = 1; e.alusrcb = 2'b01; e.chk_alu = 1; e.alu = 3'b010;
         e.irwrite = mr; e.pcen = mr; e.holds = 1;
      end else if (k == 1) begin
         e.alusrcb = 2'b11; e.chk_alu = 1; e.alu = 3'b010;
         e.illegal = (c == C_ILL);
      end else begin
         case (c)
            C_LW, C_SW: begin
               if (k == 2) begin
                  e.alusrca = 1; e.alusrcb = 2'b10; e.chk_alu = 1; e.alu = 3'b010;
               end else if (k == 3) begin
                  e.mem_req = 1; e.iord = 1; e.memwrite = (c == C_SW); e.holds = 1;
               end else begin
                  e.memtoreg = 1; e.regwrite = 1;
               end
            end
            C_RT: begin
               if (k == 2) begin
                  e.alusrca = 1; e.chk_alu = 1; e.alu = fdec(fn);
               end else begin
                  e.regdst = 1; e.regwrite = 1;
               end
            end
            C_BEQ, C_BNE: begin
               e.alusrca = 1; e.chk_alu = 1; e.alu = 3'b110; e.pcsrc = 2'b01;
               e.pcen = (c == C_BNE) ? ~z : z;
            end
            C_ADDI: begin
               if (k == 2) begin
                  e.alusrca = 1; e.alusrcb = 2'b10; e.chk_alu = 1; e.alu = 3'b010;
               end else begin
                  e.regwrite = 1;
               end
            end
            C_J: begin
               e.pcsrc = 2'b10; e.pcen = 1;
            end
            default: e = '0;
         endcase
      end
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   function automatic logic [5:0] rand_op();
      case ($urandom_range(0, 7))
         0: return 6'b100011;
         1: return 6'b101011;
         2: return 6'b000000;
         3: return 6'b000100;
         4: return 6'b000101;
         5: return 6'b001000;
         6: return 6'b000010;
         default: return 6'($urandom);
      endcase
   endfunction

   function automatic logic [5:0] rand_fn();
      case ($urandom_range(0, 5))
         0: return 6'b100000;
         1: return 6'b100010;
         2: return 6'b100100;
         3: return 6'b100101;
         4: return 6'b101010;
         default: return 6'($urandom);
      endcase
   endfunction

   // One clock: drive inputs at negedge, compare #1 later, then advance the model
   task automatic step();
      exp_t e;
      e = '0;
      @(negedge clk);
      reset = rst_next;
      if (m_new) begin
         op    = (op_q.size() != 0) ? op_q.pop_front() : rand_op();
         funct = (fn_q.size() != 0) ? fn_q.pop_front() : rand_fn();
         m_cls = classify(op);
         m_new = 1'b0;
      end else if (m_k == 0) begin
         op = 6'($urandom);
      end
      mem_ready = (mr_q.size() != 0) ? mr_q.pop_front() : ($urandom_range(0, 3) != 0);
      zero      = (z_q.size() != 0) ? z_q.pop_front() : 1'($urandom_range(0, 1));
      #1;
      if (reset) begin
         chk("reset_strobes", {26'd0, pcen, irwrite, memwrite, regwrite, mem_req, illegal_op}, 32'd0);
      end else begin
         e = model(m_cls, m_k, mem_ready, zero, funct);
         chk("mem_req", mem_req, e.mem_req);
         chk("iord", iord, e.iord);
         chk("memwrite", memwrite, e.memwrite);
         chk("irwrite", irwrite, e.irwrite);
         chk("pcen", pcen, e.pcen);
         chk("alusrca", alusrca, e.alusrca);
         chk("alusrcb", alusrcb, e.alusrcb);
         chk("pcsrc", pcsrc, e.pcsrc);
         chk("regdst", regdst, e.regdst);
         chk("memtoreg", memtoreg, e.memtoreg);
         chk("regwrite", regwrite, e.regwrite);
         chk("illegal_op", illegal_op, e.illegal);
         if (e.chk_alu) chk("alucontrol", alucontrol, e.alu);
      end
      if (reset) begin
         m_k = 0; m_new = 1'b0;
      end else if (!(e.holds && !mem_ready)) begin
         if (m_k >= ilen(m_cls) - 1) m_k = 0;
         else m_k++;
         if (m_k == 1) m_new = 1'b1;
      end
      cyc++;
   endtask

   task automatic align();
      for (int i = 0; i < 50 && m_k != 0; i++) step();
      if (m_k != 0) chk("align_timeout", m_k, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // power-on reset
      rst_next = 1'b1;
      step(); step();
      rst_next = 1'b0;
      mr_q.push_back(1'b0);
      step();
      chk("por_mem_req", mem_req, 1);
      chk("por_iord", iord, 0);
      chk("por_alusrcb", alusrcb, 2'b01);

      // reset held 3 cycles in the middle of EXECUTE
      align();
      op_q.push_back(6'b000000); fn_q.push_back(6'b101010);
      for (int i = 0; i < 60 && !(m_cls == C_RT && m_k == 2); i++) step();
      chk("reach_execute", (m_cls == C_RT && m_k == 2), 1);
      rst_next = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_regwrite", regwrite, 0);
      end
      rst_next = 1'b0;
      step();
      chk("post_rst_mem_req", mem_req, 1);
      chk("post_rst_iord", iord, 0);
      chk("post_rst_alusrcb", alusrcb, 2'b01);

      // lw, no stalls: writeback only in cycle 5, next fetch in cycle 6
      align();
      op_q.push_back(6'b100011);
      repeat (6) mr_q.push_back(1'b1);
      for (int i = 0; i < 6; i++) begin
         step();
         if (i < 5) begin
            chk("lw_regwrite", regwrite, (i == 4));
            chk("lw_memtoreg", memtoreg, (i == 4));
         end else begin
            chk("lw_next_fetch", irwrite, 1);
         end
      end

      // sw stalled 2 cycles in MEMWRITE
      align();
      op_q.push_back(6'b101011);
      mr_q.push_back(1); mr_q.push_back(1); mr_q.push_back(1);
      mr_q.push_back(0); mr_q.push_back(0); mr_q.push_back(1); mr_q.push_back(1);
      for (int i = 0; i < 7; i++) begin
         step();
         chk("sw_regwrite", regwrite, 0);
         if (i >= 3 && i <= 5) begin
            chk("sw_memwrite", memwrite, 1);
            chk("sw_iord", iord, 1);
         end
         if (i == 6) chk("sw_next_fetch", irwrite, 1);
      end

      // beq taken, then not taken
      for (int t = 0; t < 2; t++) begin
         align();
         op_q.push_back(6'b000100);
         repeat (3) mr_q.push_back(1'b1);
         z_q.push_back(0); z_q.push_back(0); z_q.push_back(t == 0);
         for (int i = 0; i < 3; i++) step();
         chk("beq_pcen", pcen, (t == 0));
         chk("beq_pcsrc", pcsrc, 2'b01);
      end

`ifdef MULTICYCLE_CTRL_BNE_EN
      // bne: branch taken when zero is low
      for (int t = 0; t < 2; t++) begin
         align();
         op_q.push_back(6'b000101);
         repeat (3) mr_q.push_back(1'b1);
         z_q.push_back(0); z_q.push_back(0); z_q.push_back(t == 0);
         for (int i = 0; i < 3; i++) step();
         chk("bne_pcen", pcen, (t != 0));
      end
`else
      // op 000101 decodes as illegal in this build
      align();
      op_q.push_back(6'b000101);
      repeat (2) mr_q.push_back(1'b1);
      step(); step();
      chk("bne_illegal", illegal_op, 1);
`endif

      // R-type slt then or
      align();
      op_q.push_back(6'b000000); op_q.push_back(6'b000000);
      fn_q.push_back(6'b101010); fn_q.push_back(6'b100101);
      repeat (8) mr_q.push_back(1'b1);
      for (int i = 0; i < 8; i++) begin
         step();
         if (i == 2) chk("slt_alu", alucontrol, 3'b111);
         if (i == 6) chk("or_alu", alucontrol, 3'b001);
         if (i == 3 || i == 7) begin
            chk("rt_regdst", regdst, 1);
            chk("rt_regwrite", regwrite, 1);
         end
      end

      // unknown opcode
      align();
      op_q.push_back(6'b111111);
      repeat (3) mr_q.push_back(1'b1);
      step(); step();
      chk("ill_pulse", illegal_op, 1);
      chk("ill_no_writes", {regwrite, memwrite, pcen, irwrite}, 4'b0000);
      step();
      chk("ill_pulse_end", illegal_op, 0);
      chk("ill_refetch", {mem_req, iord}, 2'b10);

      // random traffic with occasional reset
      for (int n = 0; n < 3000; n++) begin
         rst_next = ($urandom_range(0, 149) == 0);
         step();
      end
      rst_next = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
